// File: rtl/emoji_pkg.sv
// Emotion encodings and the select-controller state type, shared with the colour mux and ROM modules.
package emoji_pkg;

  localparam logic [1:0] EMO_HAPPY = 2'b00;
  localparam logic [1:0] EMO_SAD   = 2'b01;
  localparam logic [1:0] EMO_MAD   = 2'b10;
  localparam logic [1:0] EMO_CRAZY = 2'b11;

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } state_t;

  // Auto-cycle order: happy -> sad -> mad -> crazy -> happy.
  function automatic logic [1:0] next_emotion(input logic [1:0] sel);
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/emotion_sel_ctrl.sv
// Frame-synchronous emotion select: one-deep request slot plus an optional auto-cycle mode,
// with every select change applied only on a frame_start pulse.
module emotion_sel_ctrl
  import emoji_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned CNT_W       = $clog2(HOLD_FRAMES + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_start,
  input  logic       i_auto_en,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_sel,
  output logic       o_req_ready,
  output logic [1:0] o_sel,
  output logic       o_sel_update
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic [1:0]       sel_q, sel_d;
  logic             upd_q;
  logic             accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_MANUAL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_frame_start) begin
      case (state_q)
        S_MANUAL: if (i_auto_en)  state_d = S_AUTO;
        S_AUTO:   if (!i_auto_en) state_d = S_MANUAL;
        default:                  state_d = S_MANUAL;
      endcase
    end
  end

  always_comb begin
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    accept       = i_req_valid & ~pend_valid_q;
    if (i_frame_start) begin
      if (pend_valid_q) begin
        sel_d        = pend_sel_q;
        pend_valid_d = 1'b0;
        cnt_d        = '0;
      end else if (state_q == S_AUTO) begin
        if (cnt_q == CNT_LAST) begin
          sel_d = next_emotion(sel_q);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
      // Entering auto mode restarts the hold period regardless of the rules above.
      if (state_q == S_MANUAL && state_d == S_AUTO) cnt_d = '0;
    end
    // The slot is cleared before loading, but accept is gated by the pre-edge ready,
    // so a request can never be taken on the same edge its predecessor is consumed.
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_sel_d   = i_req_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q        <= EMO_HAPPY;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= EMO_HAPPY;
      upd_q        <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      upd_q        <= (sel_d != sel_q);
    end
  end

  assign o_req_ready  = ~pend_valid_q;
  assign o_sel        = sel_q;
  assign o_sel_update = upd_q;

endmodule

// File: tb/tb_emotion_sel_ctrl.sv
// Bench for emotion_sel_ctrl: two instances (hold 3 and hold 1) driven in parallel against a
// frame-level reference model.
module tb_emotion_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs = 1'b0;
  logic       auto_en = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'b00;

  logic       rdy0, upd0, rdy1, upd1;
  logic [1:0] sel0, sel1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  emotion_sel_ctrl #(.HOLD_FRAMES(3)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_auto_en(auto_en),
    .i_req_valid(req_valid), .i_req_sel(req_sel),
    .o_req_ready(rdy0), .o_sel(sel0), .o_sel_update(upd0)
  );

  emotion_sel_ctrl #(.HOLD_FRAMES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_auto_en(auto_en),
    .i_req_valid(req_valid), .i_req_sel(req_sel),
    .o_req_ready(rdy1), .o_sel(sel1), .o_sel_update(upd1)
  );

  // Reference model: one entry per instance, updated with plain arithmetic.
  int   hold[2] = '{3, 1};
  bit   m_auto[2];
  int   m_cnt[2];
  bit   m_pend[2];
  int   m_psel[2];
  int   m_sel[2];
  bit   m_upd[2];

  // Apply current inputs to the model, then advance one clock and settle past the edge.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      int  old_sel = m_sel[k];
      bit  take = req_valid && !m_pend[k];
      if (rst) begin
        m_auto[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_psel[k] = 0; m_sel[k] = 0; m_upd[k] = 0;
      end else begin
        if (fs) begin
          if (m_pend[k]) begin
            m_sel[k] = m_psel[k]; m_pend[k] = 0; m_cnt[k] = 0;
          end else if (m_auto[k]) begin
            if (m_cnt[k] == hold[k] - 1) begin
              m_sel[k] = (m_sel[k] + 1) % 4; m_cnt[k] = 0;
            end else begin
              m_cnt[k] = m_cnt[k] + 1;
            end
          end
          if (!m_auto[k] && auto_en) begin
            m_auto[k] = 1; m_cnt[k] = 0;
          end else if (m_auto[k] && !auto_en) begin
            m_auto[k] = 0;
          end
        end
        if (take) begin
          m_pend[k] = 1; m_psel[k] = int'(req_sel);
        end
        m_upd[k] = (m_sel[k] != old_sel);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fs = 1'b0; req_valid = 1'b0; auto_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({sel0, upd0, rdy0} !== 4'b0001) begin
      errors++; $display("FAIL reset0 got sel/upd/rdy=%b exp=0001", {sel0, upd0, rdy0});
    end
    checks++;
    if ({sel1, upd1, rdy1} !== 4'b0001) begin
      errors++; $display("FAIL reset1 got sel/upd/rdy=%b exp=0001", {sel1, upd1, rdy1});
    end
  endtask

  task automatic test_manual_idle();
    int pulses = 0;
    auto_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 4; c++) begin
        fs = (c == 3);
        tick();
        if (upd0) pulses++;
        checks++;
        if ({sel0, rdy0} !== 3'b001) begin
          errors++; $display("FAIL manual_idle f=%0d c=%0d got sel=%b rdy=%b exp sel=00 rdy=1", f, c, sel0, rdy0);
        end
      end
    end
    fs = 1'b0;
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL manual_idle_pulses got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_manual_request();
    req_valid = 1'b1; req_sel = 2'b10;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rdy0 !== 1'b0 || sel0 !== 2'b00) begin
        errors++; $display("FAIL manual_req_wait c=%0d got rdy=%b sel=%b exp rdy=0 sel=00", c, rdy0, sel0);
      end
      tick();
    end
    fs = 1'b1; tick(); fs = 1'b0;
    checks++;
    if ({sel0, upd0, rdy0} !== 4'b1011) begin
      errors++; $display("FAIL manual_req_apply got sel/upd/rdy=%b exp=1011", {sel0, upd0, rdy0});
    end
    tick();
    checks++;
    if (upd0 !== 1'b0 || sel0 !== 2'b10) begin
      errors++; $display("FAIL manual_req_pulse_width got upd=%b sel=%b exp upd=0 sel=10", upd0, sel0);
    end
  endtask

  task automatic test_auto_cycle();
    int pulses = 0;
    req_valid = 1'b1; req_sel = 2'b00; tick(); req_valid = 1'b0;
    fs = 1'b1; tick(); fs = 1'b0; tick();
    auto_en = 1'b1;
    for (int f = 1; f <= 13; f++) begin
      for (int c = 0; c < 3; c++) begin
        fs = (c == 2);
        tick();
        if (upd0) pulses++;
        checks++;
        if (sel0 !== 2'(m_sel[0]) || upd0 !== m_upd[0] || rdy0 !== !m_pend[0]) begin
          errors++; $display("FAIL auto_cycle f=%0d c=%0d got sel=%b upd=%b rdy=%b exp sel=%0d upd=%0d rdy=%0d",
                             f, c, sel0, upd0, rdy0, m_sel[0], m_upd[0], !m_pend[0]);
        end
      end
      if (f == 10) begin
        checks++;
        if (sel0 !== 2'b11) begin
          errors++; $display("FAIL auto_cycle_f10 got sel=%b exp=11", sel0);
        end
      end
    end
    fs = 1'b0;
    checks++;
    if (pulses != 4 || sel0 !== 2'b00) begin
      errors++; $display("FAIL auto_cycle_wrap got pulses=%0d sel=%b exp pulses=4 sel=00", pulses, sel0);
    end
  endtask

  task automatic test_same_edge_request();
    auto_en = 1'b0;
    fs = 1'b1; tick(); fs = 1'b0; tick();
    req_valid = 1'b1; req_sel = 2'b01; fs = 1'b1;
    tick();
    fs = 1'b0; req_sel = 2'b11;
    checks++;
    if (sel0 !== 2'(m_sel[0]) || rdy0 !== 1'b0 || upd0 !== 1'b0) begin
      errors++; $display("FAIL same_edge_not_applied got sel=%b rdy=%b upd=%b exp sel=%0d rdy=0 upd=0",
                         sel0, rdy0, upd0, m_sel[0]);
    end
    for (int c = 0; c < 8; c++) begin
      fs = (c == 3 || c == 7);
      if (c == 5) req_valid = 1'b0;
      tick();
      checks++;
      if (sel0 !== 2'(m_sel[0]) || upd0 !== m_upd[0] || rdy0 !== !m_pend[0]) begin
        errors++; $display("FAIL same_edge c=%0d got sel=%b upd=%b rdy=%b exp sel=%0d upd=%0d rdy=%0d",
                           c, sel0, upd0, rdy0, m_sel[0], m_upd[0], !m_pend[0]);
      end
    end
    fs = 1'b0;
    checks++;
    if (sel0 !== 2'b11) begin
      errors++; $display("FAIL same_edge_second got sel=%b exp=11", sel0);
    end
  endtask

  task automatic test_auto_pending();
    auto_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fs = 1'b1; tick(); fs = 1'b0; tick();
    end
    req_valid = 1'b1; req_sel = 2'b01; tick(); req_valid = 1'b0;
    fs = 1'b1; tick(); fs = 1'b0;
    checks++;
    if (sel0 !== 2'b01 || upd0 !== 1'b1) begin
      errors++; $display("FAIL auto_pend_apply got sel=%b upd=%b exp sel=01 upd=1", sel0, upd0);
    end
    for (int f = 1; f <= 3; f++) begin
      tick(); fs = 1'b1; tick(); fs = 1'b0;
      checks++;
      if (sel0 !== (f == 3 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL auto_pend_step f=%0d got sel=%b exp=%b", f, sel0, (f == 3 ? 2'b10 : 2'b01));
      end
    end
  endtask

  task automatic test_rst_pending();
    for (int f = 0; f < 3; f++) begin
      tick(); fs = 1'b1; tick(); fs = 1'b0;
    end
    checks++;
    if (sel0 !== 2'b11) begin
      errors++; $display("FAIL rst_pend_setup got sel=%b exp=11", sel0);
    end
    req_valid = 1'b1; req_sel = 2'b10; tick(); req_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({sel0, upd0, rdy0} !== 4'b0001) begin
      errors++; $display("FAIL rst_pend_clear got sel/upd/rdy=%b exp=0001", {sel0, upd0, rdy0});
    end
    auto_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick(); fs = 1'b1; tick(); fs = 1'b0;
      checks++;
      if (sel0 !== 2'b00 || upd0 !== 1'b0) begin
        errors++; $display("FAIL rst_pend_discard f=%0d got sel=%b upd=%b exp sel=00 upd=0", f, sel0, upd0);
      end
    end
  endtask

  task automatic test_hold_one();
    int pulses = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    auto_en = 1'b1;
    fs = 1'b1; tick(); fs = 1'b0;
    for (int f = 0; f < 4; f++) begin
      tick(); fs = 1'b1; tick(); fs = 1'b0;
      if (upd1) pulses++;
      checks++;
      if (sel1 !== 2'((f + 1) % 4)) begin
        errors++; $display("FAIL hold_one f=%0d got sel=%b exp=%0d", f, sel1, (f + 1) % 4);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL hold_one_pulses got=%0d exp=4", pulses);
    end
    auto_en = 1'b0;
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      fs        = ($urandom_range(0, 4) == 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) auto_en = ~auto_en;
      rst       = ($urandom_range(0, 250) == 0);
      tick();
      checks++;
      if (sel0 !== 2'(m_sel[0]) || upd0 !== m_upd[0] || rdy0 !== !m_pend[0]) begin
        errors++; $display("FAIL random0 c=%0d got sel=%b upd=%b rdy=%b exp sel=%0d upd=%0d rdy=%0d",
                           c, sel0, upd0, rdy0, m_sel[0], m_upd[0], !m_pend[0]);
      end
      checks++;
      if (sel1 !== 2'(m_sel[1]) || upd1 !== m_upd[1] || rdy1 !== !m_pend[1]) begin
        errors++; $display("FAIL random1 c=%0d got sel=%b upd=%b rdy=%b exp sel=%0d upd=%0d rdy=%0d",
                           c, sel1, upd1, rdy1, m_sel[1], m_upd[1], !m_pend[1]);
      end
    end
    rst = 1'b0; fs = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_manual_idle();
    test_manual_request();
    test_auto_cycle();
    test_same_edge_request();
    test_auto_pending();
    test_rst_pending();
    test_hold_one();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emotion_sel_ctrl.md
# emotion_sel_ctrl

Generates the 2-bit emotion select that drives the 4:1 emotion colour multiplexer ahead of the VGA driver. Accepts select requests from the processor over a valid/ready handshake and can auto-cycle through the four emotions. All select changes are applied only on a frame boundary, so an emoji never tears mid-frame.

## Interface
Parameters:
- HOLD_FRAMES, 60: frames each emotion is held in auto mode (1 s at 60 Hz). Legal range is ≥1.
- CNT_W, $clog2(HOLD_FRAMES+1): width of the frame counter.

Ports:
- i_clk  in  1  pixel clock; one clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_frame_start  in  1  one-cycle pulse at the start of vertical blanking, from the VGA timing generator.
- i_auto_en  in  1  level; 1 requests auto-cycle mode, 0 requests manual mode.
- i_req_valid  in  1  processor select request valid.
- i_req_sel  in  2  requested emotion: 00 happy, 01 sad, 10 mad, 11 crazy.
- o_req_ready  out  1  request slot empty; a request is accepted when i_req_valid & o_req_ready.
- o_sel  out  2  registered select to the colour mux.
- o_sel_update  out  1  one-cycle pulse when o_sel takes a new, different value.

## Operation
- State machine has two states: S_MANUAL and S_AUTO. Reset state is S_MANUAL.
- Mode transitions happen only on a cycle with i_frame_start=1.
  - S_MANUAL→S_AUTO when i_auto_en=1.
  - S_AUTO→S_MANUAL when i_auto_en=0.
  - Entering S_AUTO clears the frame counter.
- Pending register is one entry deep, holding {pend_valid, pend_sel}.
  - o_req_ready = ~pend_valid.
  - An accepted request loads pend_sel and sets pend_valid.
  - While pend_valid=1, new requests stall; i_req_sel is ignored.
- On each cycle with i_frame_start=1, rules apply in priority order:
  1. pend_valid=1: o_sel←pend_sel, pend_valid←0, frame counter←0. This applies in both modes.
  2. Otherwise, in S_AUTO: if counter == HOLD_FRAMES-1, then o_sel←o_sel+1 (wraps modulo 4, 11→00) and counter←0; else counter←counter+1.
  3. Otherwise, in S_MANUAL: o_sel holds and the counter holds at 0.
- Mode evaluation and select update on the same frame_start:
  - Rule 2 uses the state held before the edge.
  - The counter clear on entering S_AUTO overrides a rule-2 increment.
- o_sel_update=1 for exactly one cycle after any edge where o_sel's new value differs from its old value. Re-applying the current select produces no pulse.
- In S_MANUAL, the counter does not advance between frames.

## Timing
- Reset values: o_sel=00, o_sel_update=0, o_req_ready=1, pend_valid=0, counter=0, state=S_MANUAL.
- i_rst asserted mid-operation discards any pending request. Outputs return to reset values on the next edge.
- Latency:
  - o_sel changes on the clock edge that samples i_frame_start=1. The new value is visible the following cycle.
  - o_sel_update is asserted in that same cycle.
- Handshake:
  - Accepted at the edge where i_req_valid & o_req_ready.
  - o_req_ready drops the cycle after acceptance.
  - o_req_ready returns to 1 the cycle after the frame_start that consumes the request.
- Request accepted on the same edge as i_frame_start: it is not applied at this frame. It waits for the next i_frame_start.
- With HOLD_FRAMES=1, auto mode advances o_sel on every frame_start.
- i_req_valid held high while o_req_ready=0 is legal. That request is accepted once the slot frees.

## Structure
- Shared package emoji_pkg contains:
  - Emotion encoding constants EMO_HAPPY=2'b00, EMO_SAD=2'b01, EMO_MAD=2'b10, EMO_CRAZY=2'b11, shared with the colour mux and ROM modules.
  - The state typedef {S_MANUAL, S_AUTO}.
- No sub-module is required. The frame counter, pending register and FSM are inline; the expected size is about 150 lines.

## Test plan
- Reset, then 3 frame_start pulses with no request in manual mode → o_sel=00 throughout, o_sel_update never asserted, o_req_ready=1.
- Request i_req_sel=10 accepted mid-frame → o_req_ready=0 until the next frame_start. o_sel=10 and o_sel_update=1 the cycle after it. o_req_ready=1 again.
- HOLD_FRAMES=3, i_auto_en=1 → mode enters S_AUTO at frame 1. o_sel steps 00→01→10→11→00, one step every 3 frame_starts. There is one o_sel_update pulse per step, and the 11→00 wrap is checked.
- Request accepted on the same cycle as frame_start → not applied at that frame; applied at the next frame_start. A second request presented meanwhile is held off by o_req_ready=0.
- Auto mode with the counter at 2 of 3, request 01 pending → the next frame_start applies 01 and resets the counter. The following auto step to 10 occurs 3 frames later.
- i_rst pulsed while a request is pending in S_AUTO with o_sel=11 → next cycle o_sel=00, o_req_ready=1, state S_MANUAL. The discarded request is never applied.
